// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: time-shares one SISO core between natural/interleaved half-iterations and owns the extrinsic RAM.
// Define EARLY_STOP_EN to stop once two consecutive SISO2 passes produce identical hard decisions.
module turbo_iter_ctrl #(
    parameter int DATA_W   = 10,
    parameter int EXT_W    = 7,
    parameter int BLK_LEN  = 7,
    parameter int IDX_W    = 3,
    parameter int STRIDE   = 3,
    parameter int MAX_ITER = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [3:0]        n_iter_i,
    output logic              busy_o,
    output logic              siso_start_o,
    output logic              siso_half_o,
    output logic              siso_rd_en_o,
    output logic [IDX_W-1:0]  siso_idx_o,
    output logic [EXT_W-1:0]  siso_ext_o,
    input  logic              siso_done_i,
    input  logic              siso_llr_valid_i,
    input  logic [DATA_W-1:0] siso_llr_i,
    output logic              dec_valid_o,
    output logic [IDX_W-1:0]  dec_idx_o,
    output logic              dec_bit_o,
    output logic              done_o,
    output logic [3:0]        iter_o
);
    typedef enum logic [2:0] {IDLE, FEED, WAIT, COLLECT, FIN} state_t;
    localparam logic signed [DATA_W:0] SAT_HI = (DATA_W+1)'(2**(EXT_W-1)-1);
    localparam logic signed [DATA_W:0] SAT_LO = ~SAT_HI;

    state_t state, state_nx;
    logic [3:0] n_iter, iter, iter_nx, iter_d;
    logic half, acc, step, last, stop, dec_pass;
    logic [IDX_W-1:0] k, a, a_nx, idx, idx_d;
    logic [IDX_W:0] a_sum;
    logic signed [EXT_W-1:0] ext_mem [BLK_LEN];
    logic signed [EXT_W-1:0] ext_apr, ext_new;
    logic signed [DATA_W:0] diff;
    logic [EXT_W-1:0] ext_d;
    logic start_d, rd_en_d, dec_valid_d, done_d, busy_d;

    // a walks pi(k) = k*STRIDE mod BLK_LEN without a multiplier
    assign a_sum   = {1'b0, a} + (IDX_W+1)'(STRIDE);
    assign a_nx    = (a_sum >= (IDX_W+1)'(BLK_LEN)) ? IDX_W'(a_sum - (IDX_W+1)'(BLK_LEN)) : IDX_W'(a_sum);
    assign idx     = half ? a : k;
    assign acc     = (state == COLLECT) && siso_llr_valid_i;
    assign step    = (state == FEED) || acc;
    assign last    = step && (k == IDX_W'(BLK_LEN-1));
    assign iter_nx = iter + 4'd1;
    // the first half-pass treats the RAM as all-zero a-priori, so stale contents never leak in
    assign ext_apr = (iter == 4'd0 && !half) ? '0 : ext_mem[idx];
    assign diff    = {siso_llr_i[DATA_W-1], siso_llr_i} - {{(DATA_W+1-EXT_W){ext_apr[EXT_W-1]}}, ext_apr};
    assign ext_new = (diff > SAT_HI) ? {1'b0, {(EXT_W-1){1'b1}}} :
                     (diff < SAT_LO) ? {1'b1, {(EXT_W-1){1'b0}}} : diff[EXT_W-1:0];
    assign siso_half_o = half;

`ifdef EARLY_STOP_EN
    logic [BLK_LEN-1:0] hard_cur, hard_prev, hard_nx;
    always_comb begin
        hard_nx      = hard_cur;
        hard_nx[idx] = ~siso_llr_i[DATA_W-1];
    end
    assign stop     = (iter_nx == n_iter) || (iter_nx >= 4'd2 && hard_nx == hard_prev);
    assign dec_pass = half;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hard_cur  <= '0;
            hard_prev <= '0;
        end else if (acc && half) begin
            hard_cur <= hard_nx;
            if (last) hard_prev <= hard_nx;
        end
    end
`else
    assign stop     = iter_nx == n_iter;
    assign dec_pass = half && stop;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = FEED;
            FEED:    if (last) state_nx = WAIT;
            WAIT:    if (siso_done_i) state_nx = COLLECT;
            COLLECT: if (last) state_nx = (half && stop) ? FIN : FEED;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en_d     = state == FEED;
        start_d     = (state == FEED) && (k == '0);
        idx_d       = (state == FEED) ? idx : '0;
        ext_d       = (state == FEED) ? ext_apr : '0;
        dec_valid_d = acc && dec_pass;
        done_d      = state == FIN;
        busy_d      = (state == IDLE) ? start_i : (state != FIN);
        iter_d      = done_d ? iter : iter_o;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            {siso_start_o, siso_rd_en_o, dec_valid_o, dec_bit_o, done_o, busy_o} <= '0;
            siso_idx_o <= '0;
            siso_ext_o <= '0;
            dec_idx_o  <= '0;
            iter_o     <= '0;
        end else begin
            siso_start_o <= start_d;
            siso_rd_en_o <= rd_en_d;
            siso_idx_o   <= idx_d;
            siso_ext_o   <= ext_d;
            dec_valid_o  <= dec_valid_d;
            dec_idx_o    <= idx;
            dec_bit_o    <= ~siso_llr_i[DATA_W-1];
            done_o       <= done_d;
            busy_o       <= busy_d;
            iter_o       <= iter_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_iter <= '0;
            iter   <= '0;
            half   <= 1'b0;
            k      <= '0;
            a      <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                n_iter <= (n_iter_i == 4'd0) ? 4'd1 : (n_iter_i > 4'(MAX_ITER)) ? 4'(MAX_ITER) : n_iter_i;
                iter   <= '0;
                half   <= 1'b0;
            end
            if (step) begin
                k <= last ? '0 : k + 1'b1;
                a <= last ? '0 : a_nx;
            end
            if (state == COLLECT && last) begin
                half <= ~half;
                if (half) iter <= iter_nx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) ext_mem[idx] <= ext_new;
    end
endmodule
